// File: rtl/csi_rx_frame_monitor.sv
// ---------------------------------------------------------------------------
// csi_rx_frame_monitor
//
// Sits after the CSI depacketizer in the csi_byte_clk domain. Re-emits the raw
// pixel stream with explicit start-of-frame / end-of-line tags for the ISP,
// measures line width and frame height against expected values, drops beats
// that arrive outside a line and raises sticky timing-error flags.
//
// A one-beat hold register delays every captured beat until either the next
// beat arrives (emitted with eol=0) or the line closes (emitted with eol=1).
// That lookahead is what lets the last beat of a line carry its EOL tag.
//
// Optional feature macro: CSI_FRAME_STATS_EN
//   defined   : line_pix, frame_lines, frame_cnt and err_* are live.
//   undefined : statistics and compare logic are not built; those outputs
//               are tied to 0. Stream tagging is identical in both builds.
//
// Ports
//   clock        in   byte clock (csi_byte_clk)
//   reset        in   asynchronous, active-high
//   enable       in   block enable (cam_en); 0 forces IDLE, drops held beat
//   in_frame     in   frame-active level from the depacketizer
//   in_line      in   line-active level from the depacketizer
//   din          in   raw pixel beat (PIX_PER_BEAT pixels)
//   din_valid    in   din qualifier
//   dout         out  tagged pixel beat
//   dout_valid   out  dout qualifier
//   dout_sof     out  first beat of frame, qualified by dout_valid
//   dout_eol     out  last beat of line, qualified by dout_valid
//   err_clr      in   clears the sticky error flags (a new error wins)
//   line_pix     out  pixel count of the last completed line (saturating)
//   frame_lines  out  line count of the last completed frame (saturating)
//   frame_cnt    out  completed frames, wraps
//   err_width    out  sticky: a line width differed from EXP_WIDTH
//   err_height   out  sticky: a frame height differed from EXP_HEIGHT
//   err_stray    out  sticky: beat outside a line, or frame ended mid-line
// ---------------------------------------------------------------------------
module csi_rx_frame_monitor #(
  parameter int DATA_W       = 16,
  parameter int PIX_PER_BEAT = 2,
  parameter int EXP_WIDTH    = 1920,
  parameter int EXP_HEIGHT   = 1080,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_frame,
  input  logic              in_line,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_sof,
  output logic              dout_eol,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  line_pix,
  output logic [CNT_W-1:0]  frame_lines,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic              err_width,
  output logic              err_height,
  output logic              err_stray
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              in_frame_q, in_frame_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_vld_q, hold_vld_d;
  logic              sof_pend_q, sof_pend_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              dout_sof_q, dout_sof_d;
  logic              dout_eol_q, dout_eol_d;

  logic active;
  logic capture;
  logic line_end;
  logic frame_end;

  // A line is open only while both levels are high; either one dropping in
  // LINE closes it, so a frame cut mid-line is also a line end.
  always_comb begin
    active    = enable && (state_q != ST_IDLE);
    capture   = active && in_frame && in_line && din_valid;
    line_end  = enable && (state_q == ST_LINE) && !(in_frame && in_line);
    frame_end = active && !in_frame;
  end

  always_comb begin
    state_d      = state_q;
    in_frame_d   = in_frame;
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    sof_pend_d   = sof_pend_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    dout_sof_d   = 1'b0;
    dout_eol_d   = 1'b0;

    if (!enable) begin
      state_d    = ST_IDLE;
      hold_vld_d = 1'b0;
      sof_pend_d = 1'b0;
    end else begin
      case (state_q)
        // in_frame_q keeps a frame that was already running when enable
        // returned from being restarted halfway through.
        ST_IDLE: begin
          if (in_frame && !in_frame_q) begin
            state_d    = ST_FRAME;
            sof_pend_d = 1'b1;
          end
        end
        ST_FRAME: begin
          if (!in_frame)    state_d = ST_IDLE;
          else if (in_line) state_d = ST_LINE;
        end
        ST_LINE: begin
          if (!in_frame)     state_d = ST_IDLE;
          else if (!in_line) state_d = ST_FRAME;
        end
        default: state_d = ST_IDLE;
      endcase

      // capture and line_end are mutually exclusive by construction.
      if (capture) begin
        if (hold_vld_q) begin
          dout_d       = hold_q;
          dout_valid_d = 1'b1;
          dout_sof_d   = sof_pend_q;
          sof_pend_d   = 1'b0;
        end
        hold_d     = din;
        hold_vld_d = 1'b1;
      end else if (line_end) begin
        if (hold_vld_q) begin
          dout_d       = hold_q;
          dout_valid_d = 1'b1;
          dout_sof_d   = sof_pend_q;
          dout_eol_d   = 1'b1;
          sof_pend_d   = 1'b0;
        end
        hold_vld_d = 1'b0;
      end

      if (frame_end) begin
        sof_pend_d = 1'b0;
        hold_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      in_frame_q   <= 1'b0;
      hold_q       <= '0;
      hold_vld_q   <= 1'b0;
      sof_pend_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_sof_q   <= 1'b0;
      dout_eol_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_frame_q   <= in_frame_d;
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      sof_pend_q   <= sof_pend_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      dout_sof_q   <= dout_sof_d;
      dout_eol_q   <= dout_eol_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_sof   = dout_sof_q;
  assign dout_eol   = dout_eol_q;

`ifdef CSI_FRAME_STATS_EN
  localparam logic [CNT_W-1:0] PPB_C   = CNT_W'(PIX_PER_BEAT);
  localparam logic [CNT_W-1:0] EXP_W_C = CNT_W'(EXP_WIDTH);
  localparam logic [CNT_W-1:0] EXP_H_C = CNT_W'(EXP_HEIGHT);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] line_pix_q, line_pix_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             err_width_q, err_width_d;
  logic             err_height_q, err_height_d;
  logic             err_stray_q, err_stray_d;
  logic             new_width, new_height, new_stray;

  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    line_pix_d    = line_pix_q;
    frame_lines_d = frame_lines_q;
    frame_cnt_d   = frame_cnt_q;
    new_width     = 1'b0;
    new_height    = 1'b0;
    new_stray     = (active && in_frame && !in_line && din_valid) ||
                    (enable && (state_q == ST_LINE) && !in_frame && in_line);

    // A disabled block abandons any partial line/frame so the next frame
    // starts counting from zero; the published results are kept.
    if (!enable) begin
      pix_cnt_d  = '0;
      line_cnt_d = '0;
    end

    if (capture) pix_cnt_d = sat_add(pix_cnt_q, PPB_C);

    if (line_end) begin
      line_pix_d = pix_cnt_q;
      new_width  = (pix_cnt_q != EXP_W_C);
      pix_cnt_d  = '0;
      line_cnt_d = sat_add(line_cnt_q, CNT_W'(1));
    end

    // Uses line_cnt_d so a line closed by the frame cut is included.
    if (frame_end) begin
      frame_lines_d = line_cnt_d;
      new_height    = (line_cnt_d != EXP_H_C);
      line_cnt_d    = '0;
      frame_cnt_d   = frame_cnt_q + CNT_W'(1);
    end

    err_width_d  = (err_width_q  && !err_clr) || new_width;
    err_height_d = (err_height_q && !err_clr) || new_height;
    err_stray_d  = (err_stray_q  && !err_clr) || new_stray;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      line_pix_q    <= '0;
      frame_lines_q <= '0;
      frame_cnt_q   <= '0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
      err_stray_q   <= 1'b0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      line_pix_q    <= line_pix_d;
      frame_lines_q <= frame_lines_d;
      frame_cnt_q   <= frame_cnt_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
      err_stray_q   <= err_stray_d;
    end
  end

  assign line_pix    = line_pix_q;
  assign frame_lines = frame_lines_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;
  assign err_stray   = err_stray_q;
`else
  // Statistics not built: inputs and compare constants are intentionally
  // left without a load.
  logic [CNT_W:0] unused_stats;
  assign unused_stats = {err_clr,
                         CNT_W'(PIX_PER_BEAT) ^ CNT_W'(EXP_WIDTH) ^ CNT_W'(EXP_HEIGHT)};

  assign line_pix    = '0;
  assign frame_lines = '0;
  assign frame_cnt   = '0;
  assign err_width   = 1'b0;
  assign err_height  = 1'b0;
  assign err_stray   = 1'b0;
`endif

endmodule
